// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the loader, CPU data and CPU fetch ports.
// Provides a fetch starvation guard, a loader lock mode and one-cycle read return.
module mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_arst_n,
  input  logic                 i_ld_req,
  input  logic                 i_ld_lock,
  input  logic                 i_ld_we,
  input  logic [ADDR_W-1:0]    i_ld_addr,
  input  logic [DATA_W-1:0]    i_ld_wdata,
  output logic                 o_ld_gnt,
  output logic                 o_ld_rvalid,
  output logic [DATA_W-1:0]    o_ld_rdata,
  input  logic                 i_d_req,
  input  logic                 i_d_we,
  input  logic [DATA_W/8-1:0]  i_d_be,
  input  logic [ADDR_W-1:0]    i_d_addr,
  input  logic [DATA_W-1:0]    i_d_wdata,
  output logic                 o_d_gnt,
  output logic                 o_d_rvalid,
  output logic [DATA_W-1:0]    o_d_rdata,
  input  logic                 i_i_req,
  input  logic [ADDR_W-1:0]    i_i_addr,
  output logic                 o_i_gnt,
  output logic                 o_i_rvalid,
  output logic [DATA_W-1:0]    o_i_rdata,
  output logic                 o_mem_en,
  output logic [DATA_W/8-1:0]  o_mem_we,
  output logic [ADDR_W-1:0]    o_mem_addr,
  output logic [DATA_W-1:0]    o_mem_wdata,
  input  logic [DATA_W-1:0]    i_mem_rdata,
  output logic                 o_cpu_stall
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic {RUN, LOCK} state_e;

  typedef struct packed {
    logic              en;
    logic [BE_W-1:0]   we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  state_e           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]       vld_pipe;   // {ld, d, i} read issued last cycle
  logic             ld_gnt, d_gnt, i_gnt;
  logic             fetch_force;
  mem_req_t         mem_req;

  assign fetch_force = (state == RUN) && (wait_cnt == CNT_MAX) && i_i_req;

  // Grants are held off during reset so nothing reaches memory while it is asserted.
  always_comb begin
    ld_gnt = 1'b0;
    d_gnt  = 1'b0;
    i_gnt  = 1'b0;
    if (i_arst_n) begin
      if (state == LOCK)     ld_gnt = i_ld_req;
      else if (fetch_force)  i_gnt  = 1'b1;
      else if (i_ld_req)     ld_gnt = 1'b1;
      else if (i_d_req)      d_gnt  = 1'b1;
      else if (i_i_req)      i_gnt  = 1'b1;
    end
  end

  always_comb begin
    mem_req = '0;
    if (ld_gnt) begin
      mem_req.en    = 1'b1;
      mem_req.we    = {BE_W{i_ld_we}};
      mem_req.addr  = i_ld_addr;
      mem_req.wdata = i_ld_wdata;
    end else if (d_gnt) begin
      mem_req.en    = 1'b1;
      mem_req.we    = i_d_be & {BE_W{i_d_we}};
      mem_req.addr  = i_d_addr;
      mem_req.wdata = i_d_wdata;
    end else if (i_gnt) begin
      mem_req.en    = 1'b1;
      mem_req.addr  = i_i_addr;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {ld_gnt & ~i_ld_we, d_gnt & ~i_d_we, i_gnt};

      if (state == LOCK || !i_i_req || i_gnt) wait_cnt <= '0;
      else if (wait_cnt != CNT_MAX)           wait_cnt <= wait_cnt + CNT_W'(1);

      case (state)
        RUN:  if (ld_gnt && i_ld_lock)     state <= LOCK;
        LOCK: if (!i_ld_lock && !ld_gnt)   state <= RUN;
        default:                           state <= RUN;
      endcase
    end
  end

  assign o_ld_gnt    = ld_gnt;
  assign o_d_gnt     = d_gnt;
  assign o_i_gnt     = i_gnt;
  assign o_mem_en    = mem_req.en;
  assign o_mem_we    = mem_req.we;
  assign o_mem_addr  = mem_req.addr;
  assign o_mem_wdata = mem_req.wdata;

  assign o_ld_rvalid = vld_pipe[2];
  assign o_d_rvalid  = vld_pipe[1];
  assign o_i_rvalid  = vld_pipe[0];
  assign o_ld_rdata  = i_mem_rdata;
  assign o_d_rdata   = i_mem_rdata;
  assign o_i_rdata   = i_mem_rdata;

  assign o_cpu_stall = (state == LOCK);

  a_gnt_onehot: assert property (@(posedge i_clk) disable iff (!i_arst_n)
    $onehot0({ld_gnt, d_gnt, i_gnt}));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle vectors check grants/memory drive, a scoreboard
// checks read returns against data the bench expects memory to hold.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_req, ld_lock, ld_we, d_req, d_we, i_req;
  logic [9:0]  ld_addr, d_addr, i_addr, mem_addr;
  logic [31:0] ld_wdata, d_wdata, mem_wdata, mem_rdata;
  logic [3:0]  d_be, mem_we;
  logic        ld_gnt, d_gnt, i_gnt, ld_rvalid, d_rvalid, i_rvalid, mem_en, cpu_stall;
  logic [31:0] ld_rdata, d_rdata, i_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(8)) dut (
    .i_clk(clk), .i_arst_n(rst_n),
    .i_ld_req(ld_req), .i_ld_lock(ld_lock), .i_ld_we(ld_we), .i_ld_addr(ld_addr),
    .i_ld_wdata(ld_wdata), .o_ld_gnt(ld_gnt), .o_ld_rvalid(ld_rvalid), .o_ld_rdata(ld_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_be(d_be), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .i_i_req(i_req), .i_i_addr(i_addr), .o_i_gnt(i_gnt), .o_i_rvalid(i_rvalid),
    .o_i_rdata(i_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_cpu_stall(cpu_stall)
  );

  // Memory behind the arbiter: registered read, byte-masked write.
  logic [31:0] mem [1024];
  initial begin
    logic [31:0] w;
    for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
    mem[10'h010] = 32'h0000_1460;
    mem[10'h020] = 32'h0000_000A;
    mem[10'h030] = 32'h0000_000B;
    mem[10'h040] = 32'h0000_000C;
    mem[10'h050] = 32'h1122_3344;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        mem_rdata <= mem[mem_addr];
        w = mem[mem_addr];
        for (int b = 0; b < 4; b++) if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        mem[mem_addr] = w;
      end
    end
  end

  localparam logic [2:0] G_N = 3'b000, G_LD = 3'b100, G_D = 3'b010, G_I = 3'b001;

  typedef struct {
    logic [2:0]  ld;      // {req, lock, we}
    logic [9:0]  la;
    logic [31:0] lwd;
    logic [1:0]  d;       // {req, we}
    logic [3:0]  be;
    logic [9:0]  da;
    logic [31:0] dwd;
    logic        ir;
    logic [9:0]  ia;
    logic [2:0]  e_gnt;
    logic [3:0]  e_we;
    logic [9:0]  e_addr;
    logic        e_stall;
    logic [31:0] e_rdata;
  } vec_t;

  typedef struct { logic [2:0] port; logic [31:0] data; } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;

  function automatic vec_t mk(input logic [2:0] ld, input logic [9:0] la, input logic [31:0] lwd,
                              input logic [1:0] d, input logic [3:0] be, input logic [9:0] da,
                              input logic [31:0] dwd, input logic ir, input logic [9:0] ia,
                              input logic [2:0] eg, input logic [3:0] ewe, input logic [9:0] ea,
                              input logic es, input logic [31:0] erd);
    vec_t v;
    v.ld = ld; v.la = la; v.lwd = lwd; v.d = d; v.be = be; v.da = da; v.dwd = dwd;
    v.ir = ir; v.ia = ia; v.e_gnt = eg; v.e_we = ewe; v.e_addr = ea; v.e_stall = es;
    v.e_rdata = erd;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(3'b000, 0, 0, 2'b00, 0, 0, 0, 0, 0, G_N, 0, 0, 0, 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    {ld_req, ld_lock, ld_we} = v.ld;
    ld_addr = v.la; ld_wdata = v.lwd;
    {d_req, d_we} = v.d;
    d_be = v.be; d_addr = v.da; d_wdata = v.dwd;
    i_req = v.ir; i_addr = v.ia;
  endtask

  // One cycle: drive after the edge, check the combinational side mid-cycle.
  task automatic apply(input vec_t v, input string tag, input bit sb_en);
    @(posedge clk); #1;
    drive(v);
    @(negedge clk);
    chk({tag, " gnt"},    32'({ld_gnt, d_gnt, i_gnt}), 32'(v.e_gnt));
    chk({tag, " mem_en"}, 32'(mem_en), 32'(v.e_gnt != G_N));
    chk({tag, " mem_we"}, 32'(mem_we), 32'(v.e_we));
    chk({tag, " stall"},  32'(cpu_stall), 32'(v.e_stall));
    if (v.e_gnt != G_N) chk({tag, " mem_addr"}, 32'(mem_addr), 32'(v.e_addr));
    if (sb_en && v.e_gnt != G_N && v.e_we == 4'h0) sb.push_back('{v.e_gnt, v.e_rdata});
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " gnt"},    32'({ld_gnt, d_gnt, i_gnt}), 32'h0);
    chk({tag, " rvalid"}, 32'({ld_rvalid, d_rvalid, i_rvalid}), 32'h0);
    chk({tag, " mem_en"}, 32'(mem_en), 32'h0);
    chk({tag, " mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, " stall"},  32'(cpu_stall), 32'h0);
  endtask

  // Read-return monitor: every rvalid must match the oldest expected read.
  always @(negedge clk) begin
    logic [2:0] rv;
    sb_t        it;
    logic [31:0] rd;
    rv = {ld_rvalid, d_rvalid, i_rvalid};
    if (rv != 3'b000) begin
      if (sb.size() == 0) begin
        chk("rvalid_unexpected", 32'(rv), 32'h0);
      end else begin
        it = sb.pop_front();
        rd = (it.port == G_LD) ? ld_rdata : (it.port == G_D) ? d_rdata : i_rdata;
        chk("rvalid_port", 32'(rv), 32'(it.port));
        chk("rdata", rd, it.data);
      end
    end
  end

  vec_t tbl [11];

  initial begin
    // Reset with a request pending: nothing may be granted.
    rst_n = 1'b0;
    drive(idle());
    i_req = 1'b1; i_addr = 10'h010;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    drive(idle());
    @(posedge clk); #1 rst_n = 1'b1;

    tbl[0]  = mk(3'b000, 0, 0, 2'b00, 0, 0, 0, 1, 10'h010, G_I, 4'h0, 10'h010, 0, 32'h1460);
    tbl[1]  = idle();
    tbl[2]  = mk(3'b100, 10'h020, 0, 2'b10, 0, 10'h030, 0, 1, 10'h040, G_LD, 4'h0, 10'h020, 0, 32'hA);
    tbl[3]  = mk(3'b000, 0, 0, 2'b10, 0, 10'h030, 0, 1, 10'h040, G_D, 4'h0, 10'h030, 0, 32'hB);
    tbl[4]  = mk(3'b000, 0, 0, 2'b00, 0, 0, 0, 1, 10'h040, G_I, 4'h0, 10'h040, 0, 32'hC);
    tbl[5]  = mk(3'b000, 0, 0, 2'b11, 4'b0101, 10'h050, 32'hAABBCCDD, 0, 0, G_D, 4'b0101, 10'h050, 0, 0);
    tbl[6]  = mk(3'b000, 0, 0, 2'b10, 0, 10'h050, 0, 0, 0, G_D, 4'h0, 10'h050, 0, 32'h11BB33DD);
    tbl[7]  = mk(3'b101, 10'h060, 32'hDEADBEEF, 2'b00, 0, 0, 0, 0, 0, G_LD, 4'hF, 10'h060, 0, 0);
    tbl[8]  = mk(3'b000, 0, 0, 2'b11, 4'hF, 10'h060, 32'h01020304, 0, 0, G_D, 4'hF, 10'h060, 0, 0);
    tbl[9]  = mk(3'b100, 10'h060, 0, 2'b00, 0, 0, 0, 0, 0, G_LD, 4'h0, 10'h060, 0, 32'h01020304);
    tbl[10] = idle();
    for (int k = 0; k < 11; k++) apply(tbl[k], $sformatf("vec%0d", k), 1'b1);

    // Fetch starvation: 8 data grants, forced fetch on the 9th, then data again.
    for (int k = 0; k < 10; k++)
      apply(mk(3'b000, 0, 0, 2'b10, 0, 10'h030, 0, 1, 10'h040,
               (k == 8) ? G_I : G_D, 4'h0, (k == 8) ? 10'h040 : 10'h030, 0,
               (k == 8) ? 32'hC : 32'hB), $sformatf("starve%0d", k), 1'b1);
    apply(idle(), "starve_end", 1'b1);

    // Loader lock: CPU held off until the lock has dropped and state is back in RUN.
    apply(mk(3'b111, 10'h140, 32'h1, 2'b10, 0, 10'h140, 0, 1, 10'h010, G_LD, 4'hF, 10'h140, 0, 0), "lock0", 1'b1);
    apply(mk(3'b110, 10'h010, 0, 2'b10, 0, 10'h140, 0, 1, 10'h010, G_LD, 4'h0, 10'h010, 1, 32'h1460), "lock1", 1'b1);
    apply(mk(3'b010, 0, 0, 2'b10, 0, 10'h140, 0, 1, 10'h010, G_N, 4'h0, 0, 1, 0), "lock2", 1'b1);
    apply(mk(3'b000, 0, 0, 2'b10, 0, 10'h140, 0, 1, 10'h010, G_N, 4'h0, 0, 1, 0), "lock3", 1'b1);
    apply(mk(3'b000, 0, 0, 2'b10, 0, 10'h140, 0, 1, 10'h010, G_D, 4'h0, 10'h140, 0, 32'h1), "lock4", 1'b1);
    apply(mk(3'b000, 0, 0, 2'b00, 0, 0, 0, 1, 10'h010, G_I, 4'h0, 10'h010, 0, 32'h1460), "lock5", 1'b1);
    apply(idle(), "lock_end", 1'b1);

    // Reset while LOCK with a read in flight: the read must never return.
    apply(mk(3'b111, 10'h070, 32'h5, 2'b00, 0, 0, 0, 0, 0, G_LD, 4'hF, 10'h070, 0, 0), "rst_lock", 1'b1);
    apply(mk(3'b110, 10'h010, 0, 2'b00, 0, 0, 0, 0, 0, G_LD, 4'h0, 10'h010, 1, 0), "rst_rd", 1'b0);
    rst_n = 1'b0;
    drive(idle());
    repeat (2) @(negedge clk);
    chk_quiet("in_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("post_reset");
    apply(mk(3'b000, 0, 0, 2'b10, 0, 10'h070, 0, 0, 0, G_D, 4'h0, 10'h070, 0, 32'h5), "post_rd", 1'b1);
    apply(idle(), "tail0", 1'b1);
    apply(idle(), "tail1", 1'b1);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port unified program/data memory between three requesters:
- the debug/program loader port;
- the CPU data (load/store) port;
- the CPU instruction-fetch port.

It issues at most one memory access per cycle and returns read data one cycle later. A fetch starvation guard keeps the CPU from livelocking under back-to-back data traffic. A loader lock mode gives the loader exclusive ownership for program download while the CPU is held in stall.

Parameters:
ADDR_W, 10, word address width of memory
DATA_W, 32, data width (multiple of 8)
MAX_WAIT, 8, cycles a pending fetch may be denied before it is force-granted (>=1)

Ports:
i_clk  in  1  system clock, all state on rising edge
i_arst_n  in  1  reset, asynchronous, active-low
i_ld_req  in  1  loader access request
i_ld_lock  in  1  loader requests exclusive ownership
i_ld_we  in  1  loader write (full word)
i_ld_addr  in  ADDR_W  loader address
i_ld_wdata  in  DATA_W  loader write data
o_ld_gnt  out  1  loader access accepted this cycle
o_ld_rvalid  out  1  loader read data valid
o_ld_rdata  out  DATA_W  loader read data
i_d_req  in  1  CPU data request
i_d_we  in  1  CPU data write
i_d_be  in  DATA_W/8  byte enables for writes
i_d_addr  in  ADDR_W  CPU data address
i_d_wdata  in  DATA_W  CPU write data
o_d_gnt  out  1  data access accepted
o_d_rvalid  out  1  data read valid
o_d_rdata  out  DATA_W  data read data
i_i_req  in  1  instruction fetch request
i_i_addr  in  ADDR_W  fetch address
o_i_gnt  out  1  fetch accepted
o_i_rvalid  out  1  fetch data valid
o_i_rdata  out  DATA_W  fetch data
o_mem_en  out  1  memory access enable
o_mem_we  out  DATA_W/8  memory byte write enables
o_mem_addr  out  ADDR_W  memory address
o_mem_wdata  out  DATA_W  memory write data
i_mem_rdata  in  DATA_W  memory read data, valid one cycle after o_mem_en
o_cpu_stall  out  1  high while state is LOCK

Behaviour:

Reset (async):
- state=RUN, wait_cnt=0, rvalid pipeline cleared.
- All gnt/rvalid/mem_en/mem_we are 0.
- Any in-flight read is dropped; no rvalid is issued after reset is released.

Grants:
- Grants are combinational from the current requests and registered state.
- Exactly zero or one gnt is high per cycle.
- Memory signals are driven by the granted requester in the same cycle.
- A request is held until its gnt is seen; the requester must keep addr/data stable while req is high.

RUN priority:
- If wait_cnt==MAX_WAIT and i_i_req, grant fetch.
- Else priority is loader > data > fetch.

wait_cnt:
- Increments when i_i_req is high and fetch is not granted, saturating at MAX_WAIT.
- Clears when fetch is granted or i_i_req is low.

Memory write enables:
- Loader write: o_mem_we = all ones.
- Data write: o_mem_we = i_d_be.
- Read: o_mem_we = 0.
- Fetch: always a read.

Read return:
- A granted read in cycle N asserts the matching rvalid in cycle N+1.
- rdata = i_mem_rdata in that cycle (routed to all three rdata outputs, qualified by rvalid).
- Writes produce no rvalid.
- Throughput is one access per cycle; back-to-back reads pipeline.

State machine:
- RUN -> LOCK when a loader access is granted with i_ld_lock=1.
- LOCK: only the loader may be granted; o_d_gnt = o_i_gnt = 0 and o_cpu_stall=1. wait_cnt is held at 0 in LOCK.
- LOCK -> RUN when i_ld_lock=0 and the cycle carries no loader grant.
- A read granted on the last LOCK cycle still returns its rvalid in RUN.

Simultaneous events:
- All three requests in one cycle: only the winner is granted; the losers see gnt=0 and keep requesting.
- Data and loader write to the same address in consecutive cycles: memory order equals grant order.

Test Plan:
- Reset, then a single fetch of addr 0x010 with memory holding 0x1460 -> o_i_gnt in cycle 0, o_i_rvalid=1 and o_i_rdata=0x1460 in cycle 1, all other gnt 0.
- Loader, data and fetch all request in the same cycle, all reads -> grant order loader, data, fetch on three consecutive cycles; each rvalid one cycle after its grant.
- i_d_req held continuously plus i_i_req, MAX_WAIT=8 -> data granted for 8 cycles, fetch force-granted on the 9th, wait_cnt returns to 0.
- Loader with i_ld_lock=1 writes 0x0000_0001 to addr 320 while CPU requests -> o_cpu_stall=1, no CPU grant; after lock drops, CPU is granted on the next cycle; a data read of addr 320 returns 1.
- Data write of 0xAABBCCDD with i_d_be=4'b0101 over 0x11223344 -> read back 0x11BB33DD.
- Assert i_arst_n=0 in the cycle after a granted read -> no rvalid pulse; after release, state=RUN and all outputs are 0.
